aes128_round_ctrl: RTL
======================

Name: aes128_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer.
- Accepts one plaintext block and a 128-bit cipher key over a valid/ready handshake.
- Runs the initial AddRoundKey, then NR rounds at one round per cycle, using the team's row-major SubBytes/shiftRow/MixColumns datapath and an on-the-fly key schedule.
- Returns the ciphertext over a valid/ready handshake. Sits between the host-side block buffer and the output FIFO of the encryption core.

Parameters:
- NR, 10, number of rounds. Legal range 1..10; only 10 is FIPS-197 compliant. Smaller values are for reduced-round debug.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext/key presented
- in_ready  out  1  block can accept input
- in_pt  in  128  plaintext, FIPS-197 byte order (byte0 = [127:120], column-major)
- in_key  in  128  cipher key, FIPS-197 byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_ct  out  128  ciphertext, FIPS-197 byte order
- busy  out  1  high in ROUND or DONE
- round_idx  out  4  current round number, 0 when idle

Behaviour:
- Clocking and reset: one clock (clk); synchronous active-high reset (rst).
- Internal state layout is row-major: byte(r,c) sits at [127-8*(4r+c) -: 8], which is what shiftRow expects. Transpose on load (column-major to row-major) and on unload (row-major to column-major). The round key register stays in FIPS order; transpose it before XOR.
- FSM states: IDLE, ROUND, DONE.
- Reset: FSM=IDLE, round=0, state_reg=0, rk_reg=0. Outputs: in_ready=1, out_valid=0, busy=0, round_idx=0, out_ct=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: state_reg <= T(in_pt) ^ T(in_key); rk_reg <= in_key; round <= 1; go to ROUND.
- ROUND, with round = i:
  - rk_next = key_step(rk_reg, RCON[i]).
  - If i<NR: state_reg <= MixColumns(shiftRow(SubBytes(state_reg))) ^ T(rk_next).
  - If i==NR: MixColumns is skipped.
  - rk_reg <= rk_next.
  - If i==NR: go to DONE and clear round to 0. Otherwise round <= i+1.
- DONE:
  - out_valid=1; out_ct = T⁻¹(state_reg), held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE.
  - in_ready=0 in DONE (no input overlap).
- Latency: out_valid first high in the cycle after edge E_NR, i.e. the NR-th edge after E0.
- Throughput: one block per NR+2 cycles minimum (12 for NR=10) when out_ready is held high.
- in_valid while busy: ignored, since in_ready=0. Input fields are sampled only at the accept edge; later changes have no effect.
- out_ready low in DONE: hold out_valid/out_ct indefinitely; no data loss.
- rst asserted mid-ROUND or in DONE: abort, discard the block, return to reset values on that edge. No partial output.
- rst has priority over any simultaneous handshake.
- round_idx equals round in ROUND, 0 in IDLE and DONE.
- busy = (FSM != IDLE).
- RCON index wraps nowhere; round never exceeds NR.

Decomposition:
- Package aes_pkg holds:
  - RCON[1:10] = 01,02,04,08,10,20,40,80,1b,36
  - FSM state encoding (IDLE=2'd0, ROUND=2'd1, DONE=2'd2)
  - transpose function T and its inverse
  - xtime/GF(2^8) multiply helpers
  - S-box table
- One natural sub-module: aes_key_step (combinational). Inputs are a 128-bit key and an 8-bit rcon; output is the next round key (RotWord, SubWord, rcon XOR, word chaining).
- SubBytes, shiftRow and MixColumns are instantiated as existing datapath blocks.

Test Plan:
- Reset then FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_ct 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises exactly 10 edges after accept; round_idx steps 1..10.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_ct stable, in_ready stays 0; on out_ready=1 -> IDLE next edge, in_ready=1.
- Input while busy: toggle in_valid and change in_pt during ROUND -> ignored; ciphertext matches the originally accepted block.
- Reset mid-operation: assert rst at round 5 -> next cycle in_ready=1, out_valid=0, round_idx=0, busy=0; a fresh C.1 block then yields the correct ciphertext.
- Back-to-back: two blocks with out_ready=1 constantly -> both correct, second accept occurs 12 cycles after the first.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round constants, S-box and the
// row-major round datapath (SubBytes / shiftRow / MixColumns) plus transposes.
package aes_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned MAX_NR  = 10;

    typedef logic [BYTE_W-1:0]          byte_t;
    // Byte k of a block (k=0 is the MSB byte [127:120]) sits at element [15-k].
    typedef logic [15:0][BYTE_W-1:0]    block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    localparam byte_t RCON [1:MAX_NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant for round i (1..MAX_NR); zero outside that range.
    function automatic byte_t rcon_of(input logic [ROUND_W-1:0] i);
        byte_t r;
        r = '0;
        if (i >= ROUND_W'(1) && i <= ROUND_W'(MAX_NR)) r = RCON[i];
        return r;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul2(input byte_t b);
        return xtime(b);
    endfunction

    function automatic byte_t gf_mul3(input byte_t b);
        return xtime(b) ^ b;
    endfunction

    // Column-major (FIPS) to row-major: row-major byte 4r+c takes FIPS byte 4c+r.
    function automatic block_t transpose(input block_t x);
        block_t y;
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                y[4'(15 - (4*r + c))] = x[4'(15 - (4*c + r))];
        return y;
    endfunction

    // Row-major back to FIPS order; a 4x4 transpose is its own inverse.
    function automatic block_t transpose_inv(input block_t x);
        return transpose(x);
    endfunction

    function automatic block_t sub_bytes(input block_t x);
        block_t y;
        for (int unsigned k = 0; k < 16; k++) y[4'(k)] = SBOX[x[4'(k)]];
        return y;
    endfunction

    // Row r rotates left by r columns (row-major layout).
    function automatic block_t shift_row(input block_t x);
        block_t y;
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                y[4'(15 - (4*r + c))] = x[4'(15 - (4*r + ((c + r) % 4)))];
        return y;
    endfunction

    // Per-column circulant {02,03,01,01} multiply (row-major layout).
    function automatic block_t mix_columns(input block_t x);
        block_t y;
        byte_t a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = x[4'(15 - c)];
            a1 = x[4'(11 - c)];
            a2 = x[4'(7 - c)];
            a3 = x[4'(3 - c)];
            y[4'(15 - c)] = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
            y[4'(11 - c)] = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
            y[4'(7 - c)]  = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
            y[4'(3 - c)]  = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);
        end
        return y;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: round key i-1 -> round key i (FIPS order).
module aes_key_step
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] key,
    input  logic [BYTE_W-1:0]  rcon,
    output logic [BLOCK_W-1:0] next_key_c
);

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] rot, sub, temp;
    logic [WORD_W-1:0] n0, n1, n2, n3;

    // RotWord, SubWord, rcon injection, then chain the four words.
    always_comb begin
        w0   = key[127:96];
        w1   = key[95:64];
        w2   = key[63:32];
        w3   = key[31:0];
        rot  = {w3[23:0], w3[31:24]};
        sub  = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
        temp = sub ^ {rcon, 24'h000000};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        next_key_c = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption sequencer: one round per cycle, on-the-fly key
// schedule, valid/ready on both sides, no input/output overlap.
module aes128_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLOCK_W-1:0]  in_pt,
    input  logic [BLOCK_W-1:0]  in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLOCK_W-1:0]  out_ct,
    output logic                busy,
    output logic [ROUND_W-1:0]  round_idx
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);

    fsm_e                 fsm_q, fsm_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    block_t               state_reg, state_reg_d;
    logic [BLOCK_W-1:0]   rk_reg, rk_reg_d;
    logic [BLOCK_W-1:0]   rk_next_c;
    logic [BYTE_W-1:0]    rcon_c;

    logic                 in_ready_d, out_valid_d, busy_d;
    logic [BLOCK_W-1:0]   out_ct_d;
    logic [ROUND_W-1:0]   round_idx_d;

    assign rcon_c = rcon_of(round_q);

    aes_key_step u_key_step (
        .key        (rk_reg),
        .rcon       (rcon_c),
        .next_key_c (rk_next_c)
    );

    // State register: FSM, round counter, cipher state and round key.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= IDLE;
            round_q   <= '0;
            state_reg <= '0;
            rk_reg    <= '0;
        end else begin
            fsm_q     <= fsm_d;
            round_q   <= round_d;
            state_reg <= state_reg_d;
            rk_reg    <= rk_reg_d;
        end
    end

    // Next-state logic including the round datapath.
    always_comb begin
        block_t sr;
        fsm_d       = fsm_q;
        round_d     = round_q;
        state_reg_d = state_reg;
        rk_reg_d    = rk_reg;
        sr          = shift_row(sub_bytes(state_reg));
        unique case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_reg_d = transpose(in_pt) ^ transpose(in_key);
                    rk_reg_d    = in_key;
                    round_d     = ROUND_W'(1);
                    fsm_d       = ROUND;
                end
            end
            ROUND: begin
                rk_reg_d = rk_next_c;
                if (round_q == LAST_ROUND) begin
                    state_reg_d = sr ^ transpose(rk_next_c);
                    round_d     = '0;
                    fsm_d       = DONE;
                end else begin
                    state_reg_d = mix_columns(sr) ^ transpose(rk_next_c);
                    round_d     = round_q + ROUND_W'(1);
                end
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the ports come straight off flops.
    always_comb begin
        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
        round_idx_d = (fsm_d == ROUND) ? round_d : '0;
        out_ct_d    = (fsm_d == DONE) ? BLOCK_W'(transpose_inv(state_reg_d)) : '0;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            round_idx <= '0;
            out_ct    <= '0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            round_idx <= round_idx_d;
            out_ct    <= out_ct_d;
        end
    end

endmodule
